// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, arbiter FSM states and the latched-transfer record
// used by the master-side arbiter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_MISAL = 2'd3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  size;
  } xfer_t;

  // Natural alignment; anything wider than a word is rejected outright.
  function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] size);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && addr[0]) ||
           ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever did
// not win last time. last_owner advances only when the caller takes the grant.
module ahb_rr_arb2 import ahb_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_ls,
  input  logic take,
  output logic valid,
  output logic win_ls
);

  owner_e last_q, last_d;

  always_comb begin
    valid = req_if | req_ls;
    if (req_if && req_ls) win_ls = (last_q == OWN_IF);
    else                  win_ls = req_ls;
    last_d = last_q;
    if (take && valid) last_d = win_ls ? OWN_LS : OWN_IF;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= OWN_LS;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite master-side arbiter: shares one master port between instruction
// fetch and load/store, sequencing single transfers with wait/error/timeout.
module ahb_bus_arbiter import ahb_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_if,
  input  logic [31:0] addr_if,
  input  logic        req_ls,
  input  logic        we_ls,
  input  logic [31:0] addr_ls,
  input  logic [31:0] wdata_ls,
  input  logic [2:0]  size_ls,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  output logic        gnt_if,
  output logic        gnt_ls,
  output logic        done_if,
  output logic        done_ls,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  owner_e      owner_q, owner_d;
  xfer_t       xfer_q, xfer_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_if_q, gnt_if_d, gnt_ls_q, gnt_ls_d;
  logic        done_if_q, done_if_d, done_ls_q, done_ls_d;
  logic        err_q, err_d;
  logic        misal_pend_q, misal_pend_d;

  logic        mask_owner, arb_req_if, arb_req_ls;
  logic        arb_valid, arb_win_ls, arb_take;
  logic        fin, fin_err;

  // While the current owner's done is still in flight it sits out arbitration,
  // so its next gnt can never land on the same cycle as that done.
  always_comb begin
    mask_owner = (state_q == ST_DATA) || misal_pend_q;
    arb_req_if = req_if && !(mask_owner && (owner_q == OWN_IF));
    arb_req_ls = req_ls && !(mask_owner && (owner_q == OWN_LS));
  end

  ahb_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_if (arb_req_if),
    .req_ls (arb_req_ls),
    .take   (arb_take),
    .valid  (arb_valid),
    .win_ls (arb_win_ls)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    xfer_d       = xfer_q;
    tmo_d        = tmo_q;
    rdata_d      = rdata_q;
    gnt_if_d     = 1'b0;
    gnt_ls_d     = 1'b0;
    done_if_d    = 1'b0;
    done_ls_d    = 1'b0;
    err_d        = 1'b0;
    misal_pend_d = 1'b0;
    arb_take     = 1'b0;
    fin          = 1'b0;
    fin_err      = 1'b0;

    case (state_q)
      ST_IDLE: arb_take = arb_valid;
      ST_ADDR: begin
        if (hready) begin
          state_d = ST_DATA;
          tmo_d   = '0;
        end
      end
      ST_DATA: begin
        if (hready) begin
          fin     = 1'b1;
          fin_err = hresp;
          if (!hresp && !xfer_q.write) rdata_d = hrdata;
        end else if (tmo_q == TMO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (fin) begin
          state_d  = ST_IDLE;
          arb_take = arb_valid;
        end
      end
      ST_MISAL: begin
        state_d      = ST_IDLE;
        misal_pend_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin || misal_pend_q) begin
      done_if_d = (owner_q == OWN_IF);
      done_ls_d = (owner_q == OWN_LS);
      err_d     = fin ? fin_err : 1'b1;
    end

    if (arb_take) begin
      if (arb_win_ls) begin
        owner_d      = OWN_LS;
        gnt_ls_d     = 1'b1;
        xfer_d.addr  = addr_ls;
        xfer_d.wdata = wdata_ls;
        xfer_d.write = we_ls;
        xfer_d.size  = size_ls;
      end else begin
        owner_d      = OWN_IF;
        gnt_if_d     = 1'b1;
        xfer_d.addr  = addr_if;
        xfer_d.wdata = '0;
        xfer_d.write = 1'b0;
        xfer_d.size  = HSIZE_WORD;
      end
      state_d = misaligned(xfer_d.addr, xfer_d.size) ? ST_MISAL : ST_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_LS;
      xfer_q       <= '{addr: '0, wdata: '0, write: 1'b0, size: HSIZE_WORD};
      tmo_q        <= '0;
      rdata_q      <= '0;
      gnt_if_q     <= 1'b0;
      gnt_ls_q     <= 1'b0;
      done_if_q    <= 1'b0;
      done_ls_q    <= 1'b0;
      err_q        <= 1'b0;
      misal_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      xfer_q       <= xfer_d;
      tmo_q        <= tmo_d;
      rdata_q      <= rdata_d;
      gnt_if_q     <= gnt_if_d;
      gnt_ls_q     <= gnt_ls_d;
      done_if_q    <= done_if_d;
      done_ls_q    <= done_ls_d;
      err_q        <= err_d;
      misal_pend_q <= misal_pend_d;
    end
  end

  assign htrans  = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr   = xfer_q.addr;
  assign hwrite  = xfer_q.write;
  assign hsize   = xfer_q.size;
  assign hwdata  = xfer_q.wdata;
  assign gnt_if  = gnt_if_q;
  assign gnt_ls  = gnt_ls_q;
  assign done_if = done_if_q;
  assign done_ls = done_ls_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench: requesters push expected responses per transfer, a slave
// model plays each transfer's wait/error plan, a monitor checks every done.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_if = 1'b0, req_ls = 1'b0, we_ls = 1'b0;
  logic [31:0] addr_if = '0, addr_ls = '0, wdata_ls = '0;
  logic [2:0]  size_ls = 3'd2;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, rdata;
  logic        hwrite, gnt_if, gnt_ls, done_if, done_ls, err;
  logic [2:0]  hsize;

  ahb_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_if(req_if), .addr_if(addr_if),
    .req_ls(req_ls), .we_ls(we_ls), .addr_ls(addr_ls), .wdata_ls(wdata_ls), .size_ls(size_ls),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .gnt_if(gnt_if), .gnt_ls(gnt_ls), .done_if(done_if), .done_ls(done_ls),
    .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [2:0]  size;
    int          aw, dw;
    bit          serr;
  } txn_t;

  typedef struct {
    bit          err;
    bit          rd_ok;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    bit          ls;
    int unsigned c;
  } glog_t;

  txn_t        pq_if[$], pq_ls[$];
  exp_t        q_if[$], q_ls[$];
  int unsigned gq_if[$], gq_ls[$];
  glog_t       glog[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] model_rdata = '0;

  function automatic bit is_misal(input txn_t t);
    int unsigned bytes;
    if (t.size > 3'd2) return 1'b1;
    bytes = 32'd1 << t.size;
    return (t.addr % bytes) != 0;
  endfunction

  // Latency is counted from the gnt cycle to the done cycle.
  function automatic exp_t mk_exp(input txn_t t);
    exp_t e;
    e.rdata = t.rdata;
    if (is_misal(t)) begin
      e.err = 1'b1; e.lat = 2;
    end else if (t.dw >= TMO) begin
      e.err = 1'b1; e.lat = t.aw + TMO + 1;
    end else begin
      e.err = t.serr; e.lat = t.aw + t.dw + 2;
    end
    e.rd_ok = !e.err && !t.we;
    return e;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic we, input logic [2:0] sz, input int aw, input int dw, input bit se);
    txn_t t;
    t.addr = a; t.wdata = wd; t.rdata = rd; t.we = we; t.size = sz;
    t.aw = aw; t.dw = dw; t.serr = se;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic handle_done(input bit ls);
    exp_t        e;
    int unsigned g;
    if ((ls ? q_ls.size() : q_if.size()) == 0 || (ls ? gq_ls.size() : gq_if.size()) == 0) begin
      bound_fail(ls ? "unexpected_done_ls" : "unexpected_done_if");
      return;
    end
    e = ls ? q_ls.pop_front() : q_if.pop_front();
    g = ls ? gq_ls.pop_front() : gq_if.pop_front();
    check(ls ? "err_ls" : "err_if", 64'(err), 64'(e.err));
    if (e.rd_ok) model_rdata = e.rdata;
    check(ls ? "rdata_ls" : "rdata_if", 64'(rdata), 64'(model_rdata));
    check(ls ? "latency_ls" : "latency_if", 64'(cyc - g), 64'(e.lat));
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (gnt_if) begin gq_if.push_back(cyc); glog.push_back('{1'b0, cyc}); end
      if (gnt_ls) begin gq_ls.push_back(cyc); glog.push_back('{1'b1, cyc}); end
      if (done_if || done_ls)
        check("pulse_exclusive", 64'({gnt_if & done_if, gnt_ls & done_ls, done_if & done_ls}), 64'd0);
      if (done_if) handle_done(1'b0);
      if (done_ls) handle_done(1'b1);
    end
  end

  // Slave: plays the plan of whichever transfer was granted last.
  initial begin
    txn_t cur;
    bit   in_data = 1'b0;
    int   acnt = 0, dcnt = 0;
    cur = mk('0, '0, '0, 1'b0, 3'd2, 0, 0, 1'b0);
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_data = 1'b0; acnt = 0; hready = 1'b1; hresp = 1'b0;
        continue;
      end
      if (gnt_if && pq_if.size() > 0) cur = pq_if.pop_front();
      if (gnt_ls && pq_ls.size() > 0) cur = pq_ls.pop_front();
      if (in_data) begin
        check("data_htrans", 64'(htrans), 64'(HTRANS_IDLE));
        if (cur.we) check("hwdata", 64'(hwdata), 64'(cur.wdata));
        if (dcnt < cur.dw) begin
          hready = 1'b0;
          hresp  = cur.serr && (dcnt == cur.dw - 1);
          hrdata = $urandom;
          dcnt++;
          if (dcnt == TMO) in_data = 1'b0;
        end else begin
          hready  = 1'b1;
          hresp   = cur.serr;
          hrdata  = cur.rdata;
          in_data = 1'b0;
        end
      end else if (htrans == HTRANS_NONSEQ) begin
        check("addr_phase", 64'({haddr, hwrite, hsize, is_misal(cur)}),
              64'({cur.addr, cur.we, cur.size, 1'b0}));
        hresp  = 1'b0;
        hrdata = $urandom;
        if (acnt < cur.aw) begin
          hready = 1'b0; acnt++;
        end else begin
          hready = 1'b1; acnt = 0; in_data = 1'b1; dcnt = 0;
        end
      end else begin
        hready = 1'($urandom_range(0, 1));
        hresp  = 1'b0;
        hrdata = $urandom;
      end
    end
  end

  task automatic rand_txn(input bit ls, output txn_t t);
    int r;
    t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
    if (ls) begin
      t.we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 7);
      t.size = (r < 7) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 2) != 0 && t.size <= 3'd2)
        t.addr = t.addr - (t.addr % (32'd1 << t.size));
    end else begin
      t.we = 1'b0; t.size = 3'd2;
      if ($urandom_range(0, 7) != 0) t.addr[1:0] = 2'b00;
    end
    t.aw = ($urandom_range(0, 3) == 0) ? 1 : 0;
    t.serr = 1'b0;
    r = $urandom_range(0, 15);
    if (r < 10)      t.dw = $urandom_range(0, 2);
    else if (r < 13) begin t.serr = 1'b1; t.dw = $urandom_range(1, 2); end
    else if (r < 14) t.dw = TMO + 2;
    else             t.dw = $urandom_range(3, 5);
  endtask

  task automatic issue(input bit ls, input txn_t t);
    if (ls) begin
      addr_ls = t.addr; we_ls = t.we; wdata_ls = t.wdata; size_ls = t.size; req_ls = 1'b1;
      pq_ls.push_back(t); q_ls.push_back(mk_exp(t));
    end else begin
      addr_if = t.addr; req_if = 1'b1;
      pq_if.push_back(t); q_if.push_back(mk_exp(t));
    end
  endtask

  task automatic wait_gnt(input bit ls);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(ls ? gnt_ls : gnt_if) && n < 300);
    if (n >= 300) bound_fail(ls ? "wait_gnt_ls" : "wait_gnt_if");
    if (ls) req_ls = 1'b0; else req_if = 1'b0;
  endtask

  // mode 0: random plans and gaps; mode 1: aligned zero-wait, re-request at once
  task automatic run_req(input bit ls, input int n, input int mode);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_txn(ls, t);
      if (mode == 1) begin
        t.aw = 0; t.dw = 0; t.serr = 1'b0; t.size = 3'd2; t.addr[1:0] = 2'b00;
      end
      issue(ls, t);
      wait_gnt(ls);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_if.size() + q_ls.size()) != 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) bound_fail("drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    repeat (3) @(negedge clk);
    check("reset_addr_outs", 64'({htrans, haddr, hwrite, hsize}), 64'({2'b00, 32'h0, 1'b0, 3'b010}));
    check("reset_data_outs", {hwdata, rdata}, 64'd0);
    check("reset_pulses", 64'({gnt_if, gnt_ls, done_if, done_ls, err}), 64'd0);
    reset = 1'b0;

    // single IF fetch, zero wait
    c0 = cyc;
    issue(1'b0, mk(32'h0000_0040, '0, 32'h1234_5678, 1'b0, 3'd2, 0, 0, 1'b0));
    wait_gnt(1'b0);
    check("if_gnt_cycle", 64'(cyc), 64'(c0 + 1));
    wait_drain();

    // LS word write with three wait states
    issue(1'b1, mk(32'h1000_0008, 32'hDEAD_BEEF, '0, 1'b1, 3'd2, 0, 3, 1'b0));
    wait_gnt(1'b1);
    wait_drain();

    // misaligned half read
    issue(1'b1, mk(32'h1000_0003, '0, 32'h5555_AAAA, 1'b0, 3'd1, 0, 0, 1'b0));
    wait_gnt(1'b1);
    wait_drain();

    // two-cycle slave error
    issue(1'b1, mk(32'h2000_0000, '0, 32'h0BAD_0BAD, 1'b0, 3'd2, 0, 1, 1'b1));
    wait_gnt(1'b1);
    wait_drain();

    // hready stuck low
    issue(1'b0, mk(32'h0000_0100, '0, 32'hCAFE_F00D, 1'b0, 3'd2, 0, TMO + 4, 1'b0));
    wait_gnt(1'b0);
    wait_drain();

    // reset while an LS write sits in its data phase
    issue(1'b1, mk(32'h3000_0010, 32'h0123_4567, '0, 1'b1, 3'd2, 0, 8, 1'b0));
    wait_gnt(1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_xfer", 64'({htrans, done_ls, done_if}), 64'd0);
    q_ls.delete(); pq_ls.delete(); gq_ls.delete();
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_rdata", 64'(rdata), 64'd0);

    // both requesters held from reset: alternating grants every 2 cycles, IF first
    glog.delete();
    fork
      run_req(1'b0, 3, 1);
      run_req(1'b1, 3, 1);
    join
    wait_drain();
    if (glog.size() < 6) bound_fail("rr_grant_count");
    else begin
      for (int k = 0; k < 6; k++) begin
        check("rr_order", 64'(glog[k].ls), 64'(k % 2));
        if (k > 0) check("rr_spacing", 64'(glog[k].c - glog[k-1].c), 64'd2);
      end
    end

    // randomized traffic
    fork
      run_req(1'b0, 40, 0);
      run_req(1'b1, 40, 0);
    join
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
